mdu_dispatch: RTL and testbench
===============================

Name: mdu_dispatch

Overview:
Pipeline-side initiator for the multiply/divide unit. It accepts one RV32M request from the execute stage, stalls the pipeline, and drives the MDU start/operation/operand interface. It then waits for the MDU's done pulse, captures the result, and returns it with its destination register tag to writeback. It also handles flushes, which the MDU cannot abort, and runs a watchdog timeout.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before mdu_timeout asserts; must be >= 40 (worst-case MDU latency).
RD_W, 5, width of destination-register tag.

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
req_valid  in  1  execute stage presents an M-extension instruction
req_funct3  in  3  RV32M funct3 (000 MUL … 111 REMU)
req_rs1  in  32  rs1 value
req_rs2  in  32  rs2 value
req_rd  in  RD_W  destination register tag
flush  in  1  kill any in-flight request (branch/trap)
stall  out  1  hold pipeline
rsp_valid  out  1  one-cycle result strobe
rsp_data  out  32  result
rsp_rd  out  RD_W  destination tag for rsp_data
mdu_timeout  out  1  sticky; watchdog expired
mdu_start  out  1  one-cycle start pulse to MDU
mdu_operation  out  3  funct3 forwarded to MDU
mdu_x  out  32  operand X (rs1)
mdu_y  out  32  operand Y (rs2)
mdu_done  in  1  MDU completion pulse
mdu_result  in  32  MDU result; valid in the mdu_done cycle

Behaviour:
- Reset: state IDLE; stall, rsp_valid, mdu_start, mdu_timeout = 0; rsp_data = 0; rsp_rd = 0; mdu_operation/x/y = 0; cycle counter = 0.
- States: IDLE, ISSUE, WAIT, DRAIN, RESP.
- IDLE:
  - stall = req_valid (combinational) so the pipeline halts in the same cycle.
  - On req_valid & !flush: latch funct3/rs1/rs2/rd into mdu_operation/mdu_x/mdu_y/rd_q; go to ISSUE.
- ISSUE:
  - mdu_start = 1 for exactly this cycle; clear counter; go to WAIT. stall = 1.
  - If flush: still pulse start, because the operands were already committed; go to DRAIN.
- WAIT:
  - stall = 1; counter increments each cycle.
  - On mdu_done: rsp_data <= mdu_result; rsp_rd <= rd_q; go to RESP.
  - flush without done: go to DRAIN.
  - flush and done in the same cycle: flush wins; result is discarded; go to IDLE.
  - counter == TIMEOUT_CYCLES-1 without done: set mdu_timeout; go to IDLE with no rsp_valid.
- DRAIN:
  - stall = 0, so the pipeline refills; req_valid is ignored.
  - On mdu_done: discard the result; go to IDLE.
  - The timeout also applies here.
- RESP:
  - rsp_valid = 1 for one cycle; stall = 0; go to IDLE.
  - A new request is first sampled the following cycle.
  - Request-to-rsp_valid latency = MDU latency + 3 cycles.
- Hold rules:
  - mdu_operation, mdu_x and mdu_y stay constant from ISSUE until the cycle after mdu_done, because the MDU muxes its output on operation.
  - mdu_start is never asserted outside ISSUE and never on two consecutive cycles.
- mdu_timeout clears only on reset.
- reset mid-operation: return to IDLE immediately; the MDU is reset by the same signal.

Optional Feature:
MDU_FAST_PATH_EN: when defined, IDLE resolves these cases without starting the MDU and goes directly to RESP (latency 2 cycles, mdu_start never pulses):
- Divide by zero (rs2 == 0): DIV/DIVU -> 0xFFFFFFFF; REM/REMU -> rs1.
- Signed overflow (DIV/REM with rs1 = 0x80000000, rs2 = 0xFFFFFFFF): DIV -> 0x80000000; REM -> 0.
- Any multiply with rs1 == 0 or rs2 == 0 -> 0.

When not defined, every request goes through the MDU.

Test Plan:
- MUL, rs1 = 7, rs2 = 6, rd = 5; MDU model done after 20 cycles with 42 -> one mdu_start pulse; stall held; rsp_valid one cycle with rsp_data = 42, rsp_rd = 5; stall drops that cycle.
- DIVU, 100/7; model returns 14 -> operands stable until after done; rsp_data = 14; back-to-back second request issues 1 cycle after RESP.
- Flush 3 cycles into WAIT -> stall drops next cycle; DRAIN absorbs done; no rsp_valid; next request issues normally.
- Flush and done in the same cycle -> no rsp_valid; state IDLE next cycle.
- Model never asserts done -> mdu_timeout = 1 after 64 WAIT cycles; no response; sticky until reset.
- With MDU_FAST_PATH_EN: DIV, 0x12345678/0 -> 0xFFFFFFFF in 2 cycles, no mdu_start; REM, 0x80000000/0xFFFFFFFF -> 0. Without the macro, both requests pulse mdu_start.

Source files
------------

// File: rtl/mdu_dispatch.sv
// mdu_dispatch: execute-side initiator and result collector for the RV32M MDU.
// Define MDU_FAST_PATH_EN to resolve trivial divide/multiply cases without the MDU.
module mdu_dispatch #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int RD_W           = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_valid,
    input  logic [2:0]      req_funct3,
    input  logic [31:0]     req_rs1,
    input  logic [31:0]     req_rs2,
    input  logic [RD_W-1:0] req_rd,
    input  logic            flush,
    output logic            stall,
    output logic            rsp_valid,
    output logic [31:0]     rsp_data,
    output logic [RD_W-1:0] rsp_rd,
    output logic            mdu_timeout,
    output logic            mdu_start,
    output logic [2:0]      mdu_operation,
    output logic [31:0]     mdu_x,
    output logic [31:0]     mdu_y,
    input  logic            mdu_done,
    input  logic [31:0]     mdu_result
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_DRAIN,
        S_RESP
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic [31:0]      x_q, x_d;
    logic [31:0]      y_q, y_d;
    logic [RD_W-1:0]  rd_q, rd_d;
    logic [31:0]      rsp_data_q, rsp_data_d;
    logic [RD_W-1:0]  rsp_rd_q, rsp_rd_d;
    logic             timeout_q, timeout_d;
    logic             cnt_exp;
    logic             fast_hit;
    logic [31:0]      fast_res;

    // >= so a flush landing on the last WAIT cycle still expires in DRAIN
    assign cnt_exp = (cnt_q >= CNT_W'(TIMEOUT_CYCLES - 1));

`ifdef MDU_FAST_PATH_EN
    logic is_mul;
    logic is_rem;
    logic is_sgn;
    logic ovf;

    always_comb begin
        is_mul   = ~req_funct3[2];
        is_rem   = req_funct3[1];
        is_sgn   = ~req_funct3[0];
        ovf      = (req_rs1 == 32'h8000_0000) && (req_rs2 == 32'hFFFF_FFFF);
        fast_hit = 1'b0;
        fast_res = '0;
        if (is_mul) begin
            fast_hit = (req_rs1 == '0) || (req_rs2 == '0);
        end else if (req_rs2 == '0) begin
            fast_hit = 1'b1;
            fast_res = is_rem ? req_rs1 : 32'hFFFF_FFFF;
        end else if (is_sgn && ovf) begin
            fast_hit = 1'b1;
            fast_res = is_rem ? 32'h0 : 32'h8000_0000;
        end
    end
`else
    assign fast_hit = 1'b0;
    assign fast_res = '0;
`endif

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        op_d       = op_q;
        x_d        = x_q;
        y_d        = y_q;
        rd_d       = rd_q;
        rsp_data_d = rsp_data_q;
        rsp_rd_d   = rsp_rd_q;
        timeout_d  = timeout_q;
        stall      = 1'b0;
        mdu_start  = 1'b0;
        rsp_valid  = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                stall = req_valid;
                if (req_valid && !flush) begin
                    if (fast_hit) begin
                        rsp_data_d = fast_res;
                        rsp_rd_d   = req_rd;
                        state_d    = S_RESP;
                    end else begin
                        op_d    = req_funct3;
                        x_d     = req_rs1;
                        y_d     = req_rs2;
                        rd_d    = req_rd;
                        state_d = S_ISSUE;
                    end
                end
            end
            S_ISSUE: begin
                // operands are already committed, so start fires even on flush
                stall     = 1'b1;
                mdu_start = 1'b1;
                cnt_d     = '0;
                state_d   = flush ? S_DRAIN : S_WAIT;
            end
            S_WAIT: begin
                stall = 1'b1;
                cnt_d = cnt_q + CNT_W'(1);
                if (flush) begin
                    state_d = mdu_done ? S_IDLE : S_DRAIN;
                end else if (mdu_done) begin
                    rsp_data_d = mdu_result;
                    rsp_rd_d   = rd_q;
                    state_d    = S_RESP;
                end else if (cnt_exp) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (mdu_done) begin
                    state_d = S_IDLE;
                end else if (cnt_exp) begin
                    timeout_d = 1'b1;
                    state_d   = S_IDLE;
                end
            end
            S_RESP: begin
                rsp_valid = 1'b1;
                state_d   = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            op_q       <= '0;
            x_q        <= '0;
            y_q        <= '0;
            rd_q       <= '0;
            rsp_data_q <= '0;
            rsp_rd_q   <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            op_q       <= op_d;
            x_q        <= x_d;
            y_q        <= y_d;
            rd_q       <= rd_d;
            rsp_data_q <= rsp_data_d;
            rsp_rd_q   <= rsp_rd_d;
            timeout_q  <= timeout_d;
        end
    end

    assign rsp_data      = rsp_data_q;
    assign rsp_rd        = rsp_rd_q;
    assign mdu_timeout   = timeout_q;
    assign mdu_operation = op_q;
    assign mdu_x         = x_q;
    assign mdu_y         = y_q;

endmodule

// File: tb/tb_mdu_dispatch.sv
// tb_mdu_dispatch: scoreboard bench for mdu_dispatch with an MDU model
// and an RV32M reference computed from plain arithmetic.
module tb_mdu_dispatch;

    localparam int TO   = 64;
    localparam int RD_W = 5;
`ifdef MDU_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            req_valid = 1'b0;
    logic [2:0]      req_funct3 = '0;
    logic [31:0]     req_rs1 = '0;
    logic [31:0]     req_rs2 = '0;
    logic [RD_W-1:0] req_rd = '0;
    logic            flush = 1'b0;
    logic            stall;
    logic            rsp_valid;
    logic [31:0]     rsp_data;
    logic [RD_W-1:0] rsp_rd;
    logic            mdu_timeout;
    logic            mdu_start;
    logic [2:0]      mdu_operation;
    logic [31:0]     mdu_x;
    logic [31:0]     mdu_y;
    logic            mdu_done = 1'b0;
    logic [31:0]     mdu_result = '0;

    always #5 clk = ~clk;

    mdu_dispatch #(.TIMEOUT_CYCLES(TO), .RD_W(RD_W)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_funct3(req_funct3),
        .req_rs1(req_rs1), .req_rs2(req_rs2), .req_rd(req_rd),
        .flush(flush), .stall(stall),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_rd(rsp_rd),
        .mdu_timeout(mdu_timeout), .mdu_start(mdu_start),
        .mdu_operation(mdu_operation), .mdu_x(mdu_x), .mdu_y(mdu_y),
        .mdu_done(mdu_done), .mdu_result(mdu_result)
    );

    typedef struct packed {
        logic [31:0]     data;
        logic [RD_W-1:0] rd;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rv32m(input logic [2:0] f,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic signed [63:0] sa, sb2, ua, ub, p;
        sa  = $signed(a);
        sb2 = $signed(b);
        ua  = {32'b0, a};
        ub  = {32'b0, b};
        case (f)
            3'd0: return a * b;
            3'd1: begin p = sa * sb2; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
                p = sa / sb2;
                return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
                p = sa % sb2;
                return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit trivial(input logic [2:0] f, input logic [31:0] a,
                                   input logic [31:0] b);
        if (!FAST) return 1'b0;
        if (!f[2]) return (a == 0) || (b == 0);
        if (b == 0) return 1'b1;
        return !f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF;
    endfunction

    // MDU model: done pulse mdu_lat cycles after the start cycle
    int          mdu_lat = 20;
    bit          mdu_never = 1'b0;
    bit          busy = 1'b0;
    bit          prev_start = 1'b0;
    int          rem_cyc = 0;
    int          n_start = 0;
    logic [2:0]  cop;
    logic [31:0] cx, cy;

    always @(negedge clk) begin
        if (reset) begin
            busy       = 1'b0;
            mdu_done   = 1'b0;
            prev_start = 1'b0;
        end else begin
            mdu_done = 1'b0;
            if (mdu_start) begin
                n_start++;
                check("start_b2b", {31'b0, prev_start}, 32'd0);
                check("start_while_busy", {31'b0, busy}, 32'd0);
                if (!mdu_never) begin
                    busy    = 1'b1;
                    rem_cyc = mdu_lat;
                    cop     = mdu_operation;
                    cx      = mdu_x;
                    cy      = mdu_y;
                end
            end else if (busy) begin
                rem_cyc--;
                if (rem_cyc == 0) begin
                    check("hold_op", {29'b0, mdu_operation}, {29'b0, cop});
                    check("hold_x", mdu_x, cx);
                    check("hold_y", mdu_y, cy);
                    mdu_done   = 1'b1;
                    mdu_result = rv32m(cop, cx, cy);
                    busy       = 1'b0;
                end
            end
            prev_start = mdu_start;
        end
    end

    // response monitor
    always @(negedge clk) begin : mon
        rsp_t e;
        if (!reset && rsp_valid) begin
            if (sb.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_rsp: got data %h rd %0d, want none",
                         rsp_data, rsp_rd);
            end else begin
                e = sb.pop_front();
                check("rsp_data", rsp_data, e.data);
                check("rsp_rd", {27'b0, rsp_rd}, {27'b0, e.rd});
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [2:0] f, input logic [31:0] a,
                        input logic [31:0] b, input logic [RD_W-1:0] rd,
                        input bit expect_rsp);
        bit fast;
        fast       = trivial(f, a, b);
        req_funct3 = f;
        req_rs1    = a;
        req_rs2    = b;
        req_rd     = rd;
        req_valid  = 1'b1;
        #1;
        check("idle_stall", {31'b0, stall}, 32'd1);
        if (expect_rsp) sb.push_back('{rv32m(f, a, b), rd});
        step();
        req_valid = 1'b0;
        if (fast) begin
            check("fast_rsp", {31'b0, rsp_valid}, 32'd1);
            check("fast_nostart", {31'b0, mdu_start}, 32'd0);
        end else begin
            check("issue_start", {31'b0, mdu_start}, 32'd1);
            check("issue_stall", {31'b0, stall}, 32'd1);
            check("fwd_x", mdu_x, a);
            check("fwd_y", mdu_y, b);
        end
    endtask

    task automatic wait_rsp(input int exp_steps);
        int k;
        k = 0;
        while (!rsp_valid && k < 300) begin
            step();
            k++;
        end
        check("latency", k, exp_steps);
        check("rsp_stall", {31'b0, stall}, 32'd0);
    endtask

    task automatic txn(input logic [2:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [RD_W-1:0] rd,
                       input int lat);
        mdu_lat = lat;
        send(f, a, b, rd, 1'b1);
        wait_rsp(trivial(f, a, b) ? 0 : lat + 1);
    endtask

    task automatic wait_idle_mdu();
        int k;
        k = 0;
        while (busy && k < 200) begin
            step();
            k++;
        end
        check("mdu_drained", {31'b0, busy}, 32'd0);
        step();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int k, n0, lat;
        logic [31:0] a, b;
        logic [2:0] f;
        logic [RD_W-1:0] rd;

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_stall", {31'b0, stall}, 32'd0);
        check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_rsp_rd", {27'b0, rsp_rd}, 32'd0);
        check("rst_start", {31'b0, mdu_start}, 32'd0);
        check("rst_timeout", {31'b0, mdu_timeout}, 32'd0);
        check("rst_op", {29'b0, mdu_operation}, 32'd0);
        check("rst_x", mdu_x, 32'd0);
        check("rst_y", mdu_y, 32'd0);

        // MUL 7*6
        txn(3'd0, 32'd7, 32'd6, 5'd5, 20);
        check("mul_42", rsp_data, 32'd42);
        step();

        // DIVU 100/7, then a request held through RESP
        txn(3'd5, 32'd100, 32'd7, 5'd9, 15);
        check("divu_14", rsp_data, 32'd14);
        mdu_lat    = 12;
        req_funct3 = 3'd0;
        req_rs1    = 32'd3;
        req_rs2    = 32'd4;
        req_rd     = 5'd2;
        req_valid  = 1'b1;
        #1;
        check("resp_stall_req", {31'b0, stall}, 32'd0);
        step();
        check("resp_req_ignored", {31'b0, mdu_start}, 32'd0);
        check("b2b_idle_stall", {31'b0, stall}, 32'd1);
        sb.push_back('{32'd12, 5'd2});
        step();
        req_valid = 1'b0;
        check("b2b_start", {31'b0, mdu_start}, 32'd1);
        wait_rsp(13);
        step();

        // flush three cycles into WAIT
        mdu_lat = 20;
        send(3'd0, 32'd5, 32'd9, 5'd3, 1'b0);
        repeat (3) step();
        flush = 1'b1;
        #1;
        check("flush_wait_stall", {31'b0, stall}, 32'd1);
        step();
        flush      = 1'b0;
        req_funct3 = 3'd1;
        req_rs1    = 32'h1234;
        req_rs2    = 32'h5678;
        req_valid  = 1'b1;
        #1;
        check("drain_stall", {31'b0, stall}, 32'd0);
        step();
        check("drain_nostart", {31'b0, mdu_start}, 32'd0);
        req_valid = 1'b0;
        wait_idle_mdu();
        txn(3'd7, 32'd1000, 32'd7, 5'd11, 9);
        step();

        // flush during ISSUE
        mdu_lat = 8;
        send(3'd3, 32'hDEAD_BEEF, 32'h1111, 5'd4, 1'b0);
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("issue_flush_stall", {31'b0, stall}, 32'd0);
        wait_idle_mdu();

        // flush and done in the same cycle
        mdu_lat = 10;
        send(3'd3, 32'hFFFF_0000, 32'h0001_0003, 5'd7, 1'b0);
        repeat (10) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        check("fd_stall", {31'b0, stall}, 32'd0);
        check("fd_no_rsp", {31'b0, rsp_valid}, 32'd0);
        txn(3'd4, 32'hFFFF_FF9C, 32'd7, 5'd8, 6);
        step();

        // reset mid-operation
        mdu_lat = 30;
        send(3'd4, 32'd1000, 32'd3, 5'd4, 1'b0);
        repeat (5) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_stall", {31'b0, stall}, 32'd0);
        check("midrst_rsp_data", rsp_data, 32'd0);
        step();
        check("midrst_nostart", {31'b0, mdu_start}, 32'd0);

        // divide-by-zero and signed overflow
        n0 = n_start;
        txn(3'd4, 32'h1234_5678, 32'd0, 5'd6, 20);
        check("div0_val", rsp_data, 32'hFFFF_FFFF);
        check("div0_nstart", n_start - n0, FAST ? 32'd0 : 32'd1);
        step();
        n0 = n_start;
        txn(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 20);
        check("removf_val", rsp_data, 32'd0);
        check("removf_nstart", n_start - n0, FAST ? 32'd0 : 32'd1);
        step();

        // randomized traffic
        for (int i = 0; i < 40; i++) begin
            f  = 3'($urandom_range(0, 7));
            rd = RD_W'($urandom_range(0, 31));
            case ($urandom_range(0, 3))
                0: a = 32'd0;
                1: a = 32'h8000_0000;
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 3))
                0: b = 32'd0;
                1: b = 32'hFFFF_FFFF;
                default: b = $urandom;
            endcase
            lat = $urandom_range(1, 40);
            txn(f, a, b, rd, lat);
            step();
        end

        // watchdog timeout
        mdu_never = 1'b1;
        send(3'd0, 32'd3, 32'd5, 5'd1, 1'b0);
        k = 0;
        while (!mdu_timeout && k < 300) begin
            step();
            k++;
        end
        check("timeout_cycles", k, TO + 1);
        check("timeout_stall", {31'b0, stall}, 32'd0);
        mdu_never = 1'b0;
        step();
        txn(3'd2, 32'hFFFF_FFFE, 32'd3, 5'd10, 5);
        check("timeout_sticky", {31'b0, mdu_timeout}, 32'd1);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("timeout_cleared", {31'b0, mdu_timeout}, 32'd0);

        repeat (3) step();
        check("sb_empty", sb.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
